// File: rtl/serial_adder.sv
// Bit-serial adder (LSB first); SERIAL_ADDER_SUB_EN adds the subtract-select port sub.
// Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, and a back-to-back start is accepted in DONE.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] ra, rb, res;
   logic [CW-1:0]    cnt;
   logic             carry, cin_q;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic             ci, s, co, last;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + ~cin, so cin=0 gives a-b and cout=1 means no borrow.
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? ~cin : cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   assign ci   = (cnt == '0) ? cin_q : carry;
   assign s    = ra[0] ^ rb[0] ^ ci;
   assign co   = (ra[0] & rb[0]) | (ci & (ra[0] ^ rb[0]));
   assign last = (cnt == LAST);
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra    <= '0;
         rb    <= '0;
         res   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         cin_q <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b_eff;
                  cin_q <= cin_eff;
                  cnt   <= '0;
                  carry <= 1'b0;
               end
            end
            SHIFT: begin
               // Result fills from the top so bit 0 lands at the LSB after WIDTH shifts.
               res   <= {s, res[WIDTH-1:1]};
               ra    <= {1'b0, ra[WIDTH-1:1]};
               rb    <= {1'b0, rb[WIDTH-1:1]};
               carry <= co;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum  <= {s, res[WIDTH-1:1]};
                  cout <= co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=4 and WIDTH=2; subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start4 = 1'b0, cin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [3:0] sum4;
   logic       cout4, busy4, done4;
   logic       start2 = 1'b0, cin2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic [1:0] sum2;
   logic       cout2, busy2, done2;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub4 = 1'b0;
`endif

   int vectors = 0;
   int miscompares = 0;
   int nbusy, ndone;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub4),
`endif
      .sum(sum4), .cout(cout4), .busy(busy4), .done(done4)
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one operation on the 4-bit instance and checks timing and result.
   task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                      input logic [3:0] es, input logic ec, input string tag);
      a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      nbusy = 0; ndone = 0;
      for (int i = 0; i < 4; i++) begin
         nbusy += int'(busy4);
         ndone += int'(done4);
         @(posedge clk); #1;
      end
      chk({tag, " busy_cycles"}, 32'(nbusy), 32'd4);
      chk({tag, " early_done"}, 32'(ndone), 32'd0);
      chk({tag, " done"}, 32'(done4), 32'd1);
      chk({tag, " busy_off"}, 32'(busy4), 32'd0);
      chk({tag, " sum"}, 32'(sum4), 32'(es));
      chk({tag, " cout"}, 32'(cout4), 32'(ec));
      @(posedge clk); #1;
      chk({tag, " done_pulse_end"}, 32'(done4), 32'd0);
      chk({tag, " sum_hold"}, 32'(sum4), 32'(es));
   endtask

   task automatic op2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc,
                      input logic [1:0] es, input logic ec, input string tag);
      a2 = ta; b2 = tb_; cin2 = tc; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      chk({tag, " busy"}, 32'(busy2), 32'd1);
      @(posedge clk); #1;
      chk({tag, " not_done_yet"}, 32'(done2), 32'd0);
      @(posedge clk); #1;
      chk({tag, " done"}, 32'(done2), 32'd1);
      chk({tag, " sum"}, 32'(sum2), 32'(es));
      chk({tag, " cout"}, 32'(cout2), 32'(ec));
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst sum4", 32'(sum4), 32'd0);
      chk("rst cout4", 32'(cout4), 32'd0);
      chk("rst busy4", 32'(busy4), 32'd0);
      chk("rst done4", 32'(done4), 32'd0);
      chk("rst sum2", 32'(sum2), 32'd0);
      chk("rst done2", 32'(done2), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // B+6+1 = 0x12
      op4(4'hB, 4'h6, 1'b1, 4'h2, 1'b1, "add_b_6_1");
      // F+0+1 ripples through every bit
      op4(4'hF, 4'h0, 1'b1, 4'h0, 1'b1, "ripple");
      op4(4'h3, 4'h5, 1'b0, 4'h8, 1'b0, "add_3_5");
      op4(4'h9, 4'h9, 1'b0, 4'h2, 1'b1, "add_9_9");
      op4(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, "add_zero");

      op2(2'b11, 2'b10, 1'b1, 2'b10, 1'b1, "w2_3_2_1");
      op2(2'b10, 2'b00, 1'b0, 2'b10, 1'b0, "w2_2_0_0");

      // start and operand changes during SHIFT must be ignored
      a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      a4 = 4'h0;
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         ndone += int'(done4);
         @(posedge clk); #1;
      end
      start4 = 1'b0;
      chk("ignore done", 32'(done4), 32'd1);
      chk("ignore sum", 32'(sum4), 32'h7);
      chk("ignore cout", 32'(cout4), 32'd0);
      for (int i = 0; i < 6; i++) begin
         ndone += int'(done4);
         @(posedge clk); #1;
      end
      chk("ignore done_count", 32'(ndone), 32'd1);
      chk("ignore idle", 32'(busy4), 32'd0);

      // reset in the second SHIFT cycle aborts with no done pulse
      a4 = 4'hB; b4 = 4'h6; cin4 = 1'b1; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort sum", 32'(sum4), 32'd0);
      chk("abort cout", 32'(cout4), 32'd0);
      chk("abort busy", 32'(busy4), 32'd0);
      chk("abort done", 32'(done4), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         ndone += int'(done4);
         @(posedge clk); #1;
      end
      chk("abort no_done", 32'(ndone), 32'd0);
      op4(4'h6, 4'h7, 1'b1, 4'hE, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_SUB_EN
      sub4 = 1'b1;
      op4(4'h5, 4'h7, 1'b0, 4'hE, 1'b0, "sub_5_7");
      op4(4'h7, 4'h5, 1'b0, 4'h2, 1'b1, "sub_7_5");
      sub4 = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand/sum width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-005 SHALL provide port a  input  WIDTH  first operand.
REQ-006 SHALL provide port b  input  WIDTH  second operand.
REQ-007 SHALL provide port cin  input  1  carry-in.
REQ-008 SHALL provide port sub  input  1  subtract select; present only when SERIAL_ADDER_SUB_EN is defined.
REQ-009 SHALL provide port sum  output  WIDTH  registered result.
REQ-010 SHALL provide port cout  output  1  registered carry-out of the MSB.
REQ-011 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-012 SHALL provide port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL latch a, b, cin (and sub), clear the bit counter and the internal carry, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL compute one full-adder bit, LSB first, using the stored carry (the first bit uses cin), shift that bit into the internal result register and increment the counter.
REQ-016 After bit WIDTH-1, the FSM SHALL load sum and cout from the internal result and final carry, and enter DONE.
REQ-017 DONE SHALL return to IDLE on the next edge unless start=1, which starts a new operation back-to-back (per REQ-014).
REQ-018 Latency: with start sampled at edge k, done SHALL be high exactly in the cycle following edge k+WIDTH.
REQ-019 busy SHALL be 1 exactly while the state is SHIFT.
REQ-020 start while busy=1 SHALL be ignored; operand changes during SHIFT SHALL have no effect on the result.
REQ-021 sum and cout SHALL hold their last result until the next DONE entry.
REQ-022 The result SHALL equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-023 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap during an operation.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, sum=0, cout=0, busy=0, done=0, counter=0, internal carry=0, result=0.
REQ-025 rst asserted during SHIFT SHALL abort the operation, with no done pulse issued.
REQ-026 After rst deasserts, the first start SHALL behave per REQ-014.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN defined: port sub SHALL exist.
- sub=1: the effective operand is ~b and the effective carry-in is ~cin, so cin=0 yields a-b.
- cout=1 means no borrow.
REQ-028 Macro SERIAL_ADDER_SUB_EN undefined: port sub SHALL be absent and the block SHALL perform addition only.

Verification
REQ-029 WIDTH=4: a=4'hB, b=4'h6, cin=1, start pulse -> done high after 4 SHIFT cycles; sum=4'h2, cout=1; busy high for exactly 4 cycles.
REQ-030 WIDTH=2: a=2'b11, b=2'b10, cin=1 -> sum=2'b10, cout=1; then a=2'b10, b=2'b00, cin=0 -> sum=2'b10, cout=0.
REQ-031 WIDTH=4: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1 (full carry ripple).
REQ-032 WIDTH=4: start, then start=1 and a=4'h0 held during SHIFT -> result of the first operand set only; exactly one done pulse.
REQ-033 WIDTH=4: rst pulsed during the 2nd SHIFT cycle -> all outputs 0 immediately, no done pulse; a new start after release yields the correct sum.
REQ-034 SERIAL_ADDER_SUB_EN defined, WIDTH=4: a=4'h5, b=4'h7, cin=0, sub=1 -> sum=4'hE, cout=0 (borrow); a=4'h7, b=4'h5 -> sum=4'h2, cout=1.
